// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states,
// and the wait-counter width.
package dmem_pkg;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the core's load/store path (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte-enables and merged word, plus
// load extraction with sign/zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] ldata_o
);
  logic [31:0] wrep;
  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  always_comb begin
    be_o    = 4'hF;
    wrep    = wdata_i;
    ldata_o = rword_i;
    lbyte   = rword_i[8*addr_lo_i +: 8];
    lhalf   = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    // Half accesses key only on addr[1]; size 2'b11 falls through as a word.
    case (size_i)
      SIZE_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wrep    = {4{wdata_i[7:0]}};
        ldata_o = {{24{~uns_i & lbyte[7]}}, lbyte};
      end
      SIZE_H: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wrep    = {2{wdata_i[15:0]}};
        ldata_o = {{16{~uns_i & lhalf[15]}}, lhalf};
      end
      default: ;
    endcase
  end

  always_comb begin
    wword_o = rword_i;
    for (int i = 0; i < 4; i++)
      if (be_o[i]) wword_o[8*i +: 8] = wrep[8*i +: 8];
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, WAIT_STATES wait cycles, commit on
// entry to RESP. Define DMEM_MISALIGN_CHECK_EN to flag misaligned half/word accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input logic             clk,
  input logic             rst_n,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, uns_q, err_q;
  logic [1:0]       size_q;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic             accept, commit;

  logic [31:0] mem [DEPTH_WORDS];

  // A zero-wait accept commits on the accept edge, before the capture lands.
  logic        live;
  logic        c_write, c_uns, oor, mis, err;
  logic [1:0]  c_size;
  logic [31:0] c_addr, c_wdata, rword, wword, ldata;
  logic [3:0]  be;
  logic [AW-1:0] idx;

  assign live    = (state_q == IDLE);
  assign c_write = live ? bus.req_write    : write_q;
  assign c_uns   = live ? bus.req_unsigned : uns_q;
  assign c_size  = live ? bus.req_size     : size_q;
  assign c_addr  = live ? bus.req_addr     : addr_q;
  assign c_wdata = live ? bus.req_wdata    : wdata_q;

  assign idx   = c_addr[AW+1:2];
  assign oor   = |(c_addr >> (AW + 2));
`ifdef DMEM_MISALIGN_CHECK_EN
  assign mis   = ((c_size == SIZE_H) && c_addr[0]) || (c_size[1] && (c_addr[1:0] != 2'b00));
`else
  assign mis   = 1'b0;
`endif
  assign err   = oor | mis;
  assign rword = mem[idx];

  dmem_lane_align u_align (
    .size_i    (c_size),
    .uns_i     (c_uns),
    .addr_lo_i (c_addr[1:0]),
    .wdata_i   (c_wdata),
    .rword_i   (rword),
    .be_o      (be),
    .wword_o   (wword),
    .ldata_o   (ldata)
  );

  assign bus.req_ready = rst_n && (state_q == IDLE);
  assign bus.rsp_valid = rst_n && (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (WAIT_STATES == 0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(WAIT_STATES - 1);
        end
      end
      WAIT: if (cnt_q == '0) begin
        state_d = RESP;
        commit  = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= bus.req_write;
        uns_q   <= bus.req_unsigned;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (commit) begin
        rdata_q <= (err || c_write) ? 32'h0 : ldata;
        err_q   <= err;
      end
    end
  end

  // Array is not reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_n && commit && c_write && !err && (be != 4'h0))
      mem[idx] <= wword;
  end
endmodule
